// File: rtl/prescalador_120hz.sv
// Divides the board clock down to a 50 %-duty square wave near OUT_FREQ_HZ,
// and also gives a one-cycle strobe on each rising edge of that wave.
module prescalador_120hz #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int OUT_FREQ_HZ = 120
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_clk_120Hz,
  output logic o_tick_120Hz
);

  localparam int HALF_PERIOD = (CLK_FREQ_HZ + OUT_FREQ_HZ) / (2 * OUT_FREQ_HZ);
  localparam int CNT_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  if (OUT_FREQ_HZ <= 0) begin : g_bad_out_freq
    $error("prescalador_120hz: OUT_FREQ_HZ must be positive");
  end
  if (2 * OUT_FREQ_HZ > CLK_FREQ_HZ) begin : g_bad_ratio
    $error("prescalador_120hz: 2*OUT_FREQ_HZ must not exceed CLK_FREQ_HZ");
  end

  logic [CNT_W-1:0] cnt_reg;
  logic             wrap;

  assign wrap = (cnt_reg == CNT_LAST);

  // The tick is produced alongside the 0->1 toggle so both land in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_reg      <= '0;
      o_clk_120Hz  <= 1'b0;
      o_tick_120Hz <= 1'b0;
    end else begin
      o_tick_120Hz <= wrap && !o_clk_120Hz;
      if (wrap) begin
        cnt_reg     <= '0;
        o_clk_120Hz <= ~o_clk_120Hz;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prescalador_120hz.sv
// Scoreboard bench: two prescalers (half-period 5 and 1) share one reset;
// the stimulus queues expected outputs per edge and a monitor checks them.
module tb_prescalador_120hz;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk5, tick5, clk1, tick1;

  typedef struct {
    logic c5;
    logic t5;
    logic c1;
    logic t1;
    int   edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  bit   win = 1'b0;
  int   ticks5 = 0;
  int   ticks1 = 0;
  int   edge_cnt = 0;

  always #5 clk = ~clk;

  prescalador_120hz #(.CLK_FREQ_HZ(1200), .OUT_FREQ_HZ(120)) dut5 (
    .i_clk(clk), .i_reset(rst), .o_clk_120Hz(clk5), .o_tick_120Hz(tick5)
  );

  prescalador_120hz #(.CLK_FREQ_HZ(240), .OUT_FREQ_HZ(120)) dut1 (
    .i_clk(clk), .i_reset(rst), .o_clk_120Hz(clk1), .o_tick_120Hz(tick1)
  );

  task automatic check(input string name, input logic act, input logic req, input int e);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge %0d: got %b expected %b", name, e, act, req);
    end
  endtask

  // Drive reset for the coming edge and queue what each output must read after it.
  // With k edges since release, half-period H: output = (k/H) odd, tick when k%(2H)==H.
  task automatic step(input logic r);
    exp_t e;
    @(negedge clk);
    rst = r;
    edge_cnt++;
    if (r) k = 0;
    else   k++;
    e.c5 = r ? 1'b0 : (((k / 5) % 2) == 1);
    e.t5 = r ? 1'b0 : ((k % 10) == 5);
    e.c1 = r ? 1'b0 : ((k % 2) == 1);
    e.t1 = r ? 1'b0 : ((k % 2) == 1);
    e.edge_no = edge_cnt;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("clk_h5", clk5, e.c5, e.edge_no);
        check("tick_h5", tick5, e.t5, e.edge_no);
        check("clk_h1", clk1, e.c1, e.edge_no);
        check("tick_h1", tick1, e.t1, e.edge_no);
        if (win) begin
          ticks5 += int'(tick5);
          ticks1 += int'(tick1);
        end
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 20; i++) step(1'b1);
    win = 1'b1;
    for (int i = 0; i < 100; i++) step(1'b0);
    // Window flag is read by the monitor one edge late, so close it after the last sample.
    @(posedge clk);
    #3;
    win = 1'b0;
    // Eight more edges leave the h5 output high with its counter at 3.
    for (int i = 0; i < 8; i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 15; i++) step(1'b0);
    step(1'b1);
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (ticks5 != 10) begin
      errors++;
      $display("FAIL tick_count_h5: got %0d expected 10", ticks5);
    end
    checks++;
    if (ticks1 != 50) begin
      errors++;
      $display("FAIL tick_count_h1: got %0d expected 50", ticks1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
